// File: rtl/cond_pkg.sv
// Shared condition-code definitions for the ARM pipeline.
// Contents:
//   cond_e    : 4-bit ARM condition field encodings (EQ..AL, NV)
//   N,Z,C,V   : bit positions inside a 4-bit NZCV flags word
//   cond_eval : pure condition evaluator. It is also used by the
//               decode-stage branch predictor.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  // NV (and any unlisted encoding) evaluates to 0, so the result is never X.
  function automatic logic cond_eval(input cond_e cond, input logic [3:0] f);
    logic r;
    r = 1'b0;
    case (cond)
      EQ: r = f[Z];
      NE: r = ~f[Z];
      CS: r = f[C];
      CC: r = ~f[C];
      MI: r = f[N];
      PL: r = ~f[N];
      VS: r = f[V];
      VC: r = ~f[V];
      HI: r = f[C] & ~f[Z];
      LS: r = ~f[C] | f[Z];
      GE: r = (f[N] == f[V]);
      LT: r = (f[N] != f[V]);
      GT: r = ~f[Z] & (f[N] == f[V]);
      LE: r = f[Z] | (f[N] != f[V]);
      AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_flags_unit_bank.sv
// cond_flags_bank: NCTX x 4-bit NZCV flag registers.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   alu_we[1:0]          : ALU write enables, [1]=NZ, [0]=CV (already gated)
//   alu_ctx, alu_flags   : ALU write context and NZCV value
//   ld_en, ld_ctx,
//   ld_flags             : direct full-word load; wins over ALU on same context
//   ev_ctx / ev_flags    : evaluation read port (combinational)
//   rd_ctx / rd_flags    : readout read port (combinational)
// Context indices >= NCTX match no register: writes drop, reads return 0.
module cond_flags_bank #(
  parameter int NCTX = 4,
  parameter int CTXW = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      alu_we,
  input  logic [CTXW-1:0] alu_ctx,
  input  logic [3:0]      alu_flags,
  input  logic            ld_en,
  input  logic [CTXW-1:0] ld_ctx,
  input  logic [3:0]      ld_flags,
  input  logic [CTXW-1:0] ev_ctx,
  output logic [3:0]      ev_flags,
  input  logic [CTXW-1:0] rd_ctx,
  output logic [3:0]      rd_flags
);

  logic [3:0] flags_q [NCTX];
  logic [3:0] flags_d [NCTX];

  always_comb begin
    for (int i = 0; i < NCTX; i++) begin
      flags_d[i] = flags_q[i];
      if (alu_ctx == CTXW'(i)) begin
        if (alu_we[1]) flags_d[i][3:2] = alu_flags[3:2];
        if (alu_we[0]) flags_d[i][1:0] = alu_flags[1:0];
      end
      // Load is applied last so it overrides every bit of an ALU write.
      if (ld_en && (ld_ctx == CTXW'(i))) flags_d[i] = ld_flags;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCTX; i++) begin
      if (reset) flags_q[i] <= 4'b0000;
      else       flags_q[i] <= flags_d[i];
    end
  end

  always_comb begin
    ev_flags = 4'b0000;
    rd_flags = 4'b0000;
    for (int i = 0; i < NCTX; i++) begin
      if (ev_ctx == CTXW'(i)) ev_flags = flags_q[i];
      if (rd_ctx == CTXW'(i)) rd_flags = flags_q[i];
    end
  end

endmodule

// File: rtl/cond_flags_unit.sv
// cond_flags_unit: multi-context ARM condition check, NZCV flags and
// skip counters. It also holds the Execute->Memory condition register.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   e_valid, e_ctx, e_cond     : Execute instruction valid, context, cond field
//   e_flagw[1:0]               : flag write enables, [1]=NZ, [0]=CV
//   alu_flags                  : NZCV result from the ALU this cycle
//   stall                      : freezes flags (ALU path), counters, M register
//   flush                      : kills Execute instruction, clears M valid/undef
//   ld_en, ld_ctx, ld_flags    : direct flags load, honoured during stall
//   e_condex                   : combinational condition result
//   m_valid, m_ctx, m_undef    : registered M-stage info
//   rd_ctx, rd_flags,
//   rd_skipcnt                 : combinational readout of register state
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int NCTX = 4,
  parameter int CNTW = 16,
  localparam int CTXW = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            e_valid,
  input  logic [CTXW-1:0] e_ctx,
  input  logic [3:0]      e_cond,
  input  logic [1:0]      e_flagw,
  input  logic [3:0]      alu_flags,
  input  logic            stall,
  input  logic            flush,
  input  logic            ld_en,
  input  logic [CTXW-1:0] ld_ctx,
  input  logic [3:0]      ld_flags,
  output logic            e_condex,
  output logic            m_valid,
  output logic [CTXW-1:0] m_ctx,
  output logic            m_undef,
  input  logic [CTXW-1:0] rd_ctx,
  output logic [3:0]      rd_flags,
  output logic [CNTW-1:0] rd_skipcnt
);

  logic [3:0] ev_flags;
  logic       cond_pass;
  logic       e_live;
  logic [1:0] alu_we;
  logic       skip_inc;

  cond_flags_bank #(.NCTX(NCTX), .CTXW(CTXW)) u_bank (
    .clk       (clk),
    .reset     (reset),
    .alu_we    (alu_we),
    .alu_ctx   (e_ctx),
    .alu_flags (alu_flags),
    .ld_en     (ld_en),
    .ld_ctx    (ld_ctx),
    .ld_flags  (ld_flags),
    .ev_ctx    (e_ctx),
    .ev_flags  (ev_flags),
    .rd_ctx    (rd_ctx),
    .rd_flags  (rd_flags)
  );

  assign cond_pass = cond_eval(cond_e'(e_cond), ev_flags);
  assign e_live    = e_valid & ~flush;
  assign e_condex  = e_live & cond_pass;
  assign alu_we    = (e_condex & ~stall) ? e_flagw : 2'b00;
  // NV fails cond_eval, so it is counted as skipped as well.
  assign skip_inc  = e_live & ~stall & ~cond_pass;

  // Per-context saturating skip counters.
  logic [CNTW-1:0] skip_q [NCTX];
  logic [CNTW-1:0] skip_d [NCTX];

  always_comb begin
    for (int i = 0; i < NCTX; i++) begin
      skip_d[i] = skip_q[i];
      if (skip_inc && (e_ctx == CTXW'(i)) && (skip_q[i] != {CNTW{1'b1}}))
        skip_d[i] = skip_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCTX; i++) begin
      if (reset) skip_q[i] <= '0;
      else       skip_q[i] <= skip_d[i];
    end
  end

  always_comb begin
    rd_skipcnt = '0;
    for (int i = 0; i < NCTX; i++)
      if (rd_ctx == CTXW'(i)) rd_skipcnt = skip_q[i];
  end

  // M-stage register. A flush under stall still clears valid/undef.
  logic            m_valid_q, m_valid_d;
  logic [CTXW-1:0] m_ctx_q,   m_ctx_d;
  logic            m_undef_q, m_undef_d;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctx_d   = m_ctx_q;
    m_undef_d = m_undef_q;
    if (!stall) begin
      m_valid_d = e_condex;
      m_ctx_d   = e_ctx;
      m_undef_d = e_live & (e_cond == 4'hF);
    end else if (flush) begin
      m_valid_d = 1'b0;
      m_undef_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_ctx_q   <= '0;
      m_undef_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctx_q   <= m_ctx_d;
      m_undef_q <= m_undef_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_ctx   = m_ctx_q;
  assign m_undef = m_undef_q;

endmodule

// File: doc/cond_flags_unit.md
# cond_flags_unit

Multi-context condition-check and flags unit for the pipelined ARM core, the successor to the single-context condition checker. It holds one NZCV flags register per hardware context and evaluates the 4-bit ARM condition field of the Execute-stage instruction against that context's flags. It applies split NZ/CV flag writes gated by the condition result and registers the result into the Memory stage. It also keeps per-context saturating counters of condition-skipped instructions.

## Interface
Parameters:
- NCTX, 4, number of hardware contexts (≥1); CTXW = max(1,$clog2(NCTX)) is derived, not overridable
- CNTW, 16, width of each skip counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- e_valid  in  1  Execute-stage instruction valid
- e_ctx  in  CTXW  context of Execute instruction
- e_cond  in  4  condition field, instr[31:28]
- e_flagw  in  2  flag write enables; [1]=NZ, [0]=CV
- alu_flags  in  4  {N,Z,C,V} from the ALU, same cycle
- stall  in  1  freezes flags, counters and M-stage register
- flush  in  1  kills the Execute instruction and clears M-stage valid
- ld_en  in  1  direct flags load (exception return / MSR)
- ld_ctx  in  CTXW  context for direct load
- ld_flags  in  4  value for direct load
- e_condex  out  1  combinational condition result for the Execute instruction
- m_valid  out  1  registered: instruction passed to M and executed
- m_ctx  out  CTXW  registered context of M instruction
- m_undef  out  1  registered: the M-stage instruction had cond=4'b1111
- rd_ctx  in  CTXW  readout select
- rd_flags  out  4  combinational flags of rd_ctx
- rd_skipcnt  out  CNTW  combinational skip count of rd_ctx

## Operation
- Condition decode is per ARM: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. The value 4'b1111 is NV: e_condex=0 and the undefined marker is set. It never produces X.
- e_condex = e_valid & ~flush & cond_eval(e_cond, flags[e_ctx]).
- Flag update at the clock edge, when ~stall:
  - flags[e_ctx][3:2] <= alu_flags[3:2] if e_condex & e_flagw[1]
  - flags[e_ctx][1:0] <= alu_flags[1:0] if e_condex & e_flagw[0]
- Direct load: ld_en writes all 4 bits of flags[ld_ctx]. ld_en is honoured even during stall.
- Collision: when ld_en and the ALU update target the same context in the same cycle, ld_en wins for all bits. Different contexts update independently.
- Skip counter: when e_valid & ~flush & ~stall & ~cond_pass, skipcnt[e_ctx] increments and saturates at 2^CNTW-1. NV counts as skipped.
- M register, when ~stall:
  - m_valid <= e_condex
  - m_ctx <= e_ctx
  - m_undef <= e_valid & ~flush & (e_cond==4'hF)
- flush overrides stall: it clears m_valid and m_undef even when stall=1.
- An ctx index ≥ NCTX (non-power-of-2 NCTX) is ignored for writes and reads back as 0.

## Timing
- e_condex has zero latency. Flag writes are visible to evaluation in the next cycle, so back-to-back dependent instructions in the same context need no bypass.
- m_* outputs lag by 1 cycle and hold for as long as stall is asserted.
- rd_flags and rd_skipcnt reflect register state and do not see the current cycle's write.
- Reset values: all flags 4'b0000, all counters 0, m_valid=0, m_undef=0, m_ctx=0.
- reset takes priority over ld_en, stall and flush. Asserting reset mid-stream drops the in-flight M instruction.

## Structure
- Shared package cond_pkg holds:
  - cond_e enum (EQ..AL, NV)
  - flag bit index constants N=3, Z=2, C=1, V=0
  - pure function cond_eval(cond_e, logic[3:0]) returning logic, reused by the decode-stage branch predictor
- Sub-module cond_flags_bank: NCTX×4 flag registers with two write ports (ALU-split, load) and one evaluation read plus one readout read. The top level holds the counters and the M register.

## Test plan
- Reset, then ld_en ctx0 = 4'b0100; e_cond=EQ ctx0 → e_condex=1. Next cycle m_valid=1.
- ctx1 flags 0000; e_cond=EQ, e_flagw=2'b11, alu_flags=1111 → e_condex=0, ctx1 flags stay 0000, rd_skipcnt(ctx1)=1.
- AL on ctx2 with e_flagw=2'b10, alu_flags=1011 → ctx2 flags become 1000 (CV untouched). The next GE instruction on ctx2 gives e_condex=0.
- Same cycle: ALU writes ctx0 with 1111 and ld_en ctx0 with 0010 → flags[0]=0010.
- stall held 3 cycles with e_valid=1 and a failing condition → counters, flags and m_* frozen. Add flush during the stall → m_valid=0 on the next edge.
- Preset a counter to max via 2^CNTW-1 skips (CNTW=4 build: 15 skips) → the 16th skip stays at 15. Also e_cond=4'hF → e_condex=0 and m_undef=1 on the next cycle.
